// File: rtl/vc_fifo_pkg.sv
// Shared types and width helpers for the multi-queue virtual-channel FIFO.
// Queue state fields are sized for the largest supported DEPTH (below 65536).
package vc_fifo_pkg;

    localparam int QFIELD_W = 16;

    typedef struct packed {
        logic [QFIELD_W-1:0] head;
        logic [QFIELD_W-1:0] tail;
        logic [QFIELD_W-1:0] count;
    } qstate_t;

    function automatic int vcWidth(input int numVc);
        return (numVc > 1) ? $clog2(numVc) : 1;
    endfunction

    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Pointers wrap explicitly, so DEPTH need not be a power of two.
    function automatic logic [QFIELD_W-1:0] wrapInc(input logic [QFIELD_W-1:0] ptr,
                                                    input int depth);
        return (ptr == QFIELD_W'(depth - 1)) ? '0 : ptr + QFIELD_W'(1);
    endfunction

endpackage

// File: rtl/vc_fifo_qctrl.sv
// Pointer and occupancy bookkeeping for a single virtual-channel queue.
// Status flags are registered from the next-state count.
module vc_fifo_qctrl
    import vc_fifo_pkg::*;
#(
    parameter int DEPTH        = 24,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int PW          = ptrWidth(DEPTH),
    localparam int CW          = cntWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_acc_i,
    input  logic          pop_acc_i,
    output logic [PW-1:0] head_o,
    output logic [PW-1:0] tail_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          afull_o,
    output logic          empty_o
);

    qstate_t qState_q;
    qstate_t qState_d;
    logic    full_q;
    logic    afull_q;
    logic    empty_q;

    always_comb begin
        qState_d = qState_q;
        if (push_acc_i) begin
            qState_d.tail = wrapInc(qState_q.tail, DEPTH);
        end
        if (pop_acc_i) begin
            qState_d.head = wrapInc(qState_q.head, DEPTH);
        end
        unique case ({push_acc_i, pop_acc_i})
            2'b10:   qState_d.count = qState_q.count + QFIELD_W'(1);
            2'b01:   qState_d.count = qState_q.count - QFIELD_W'(1);
            default: qState_d.count = qState_q.count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qState_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            qState_q <= qState_d;
            full_q   <= (qState_d.count == QFIELD_W'(DEPTH));
            afull_q  <= (qState_d.count >= QFIELD_W'(AFULL_THRESH));
            empty_q  <= (qState_d.count == '0);
        end
    end

    assign head_o  = qState_q.head[PW-1:0];
    assign tail_o  = qState_q.tail[PW-1:0];
    assign count_o = qState_q.count[CW-1:0];
    assign full_o  = full_q;
    assign afull_o = afull_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/vc_fifo.sv
// Multi-queue FIFO: NUM_VC independent queues sharing one storage array,
// one write port and one read port, each steered by a VC index.
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int NUM_VC       = 2,
    parameter int DEPTH        = 24,
    parameter int WIDTH        = 32,
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter int RLATENCY     = 0,
    localparam int VCW         = vcWidth(NUM_VC),
    localparam int CW          = cntWidth(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [VCW-1:0]       i_push_vc,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_pop,
    input  logic [VCW-1:0]       i_pop_vc,
    output logic [WIDTH-1:0]     o_rdata,
    output logic                 o_rvalid,
    output logic [NUM_VC-1:0]    o_full,
    output logic [NUM_VC-1:0]    o_afull,
    output logic [NUM_VC-1:0]    o_empty,
    output logic [NUM_VC*CW-1:0] o_count,
    output logic                 o_overflow,
    output logic                 o_underflow,
    input  logic                 i_clr_err
);

    localparam int PW      = ptrWidth(DEPTH);
    localparam int ENTRIES = NUM_VC * DEPTH;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int NVP     = 1 << VCW;

    logic [PW-1:0]     headArr [NUM_VC];
    logic [PW-1:0]     tailArr [NUM_VC];
    logic [NUM_VC-1:0] fullVec;
    logic [NUM_VC-1:0] afullVec;
    logic [NUM_VC-1:0] emptyVec;
    logic [NUM_VC-1:0] pushAccVec;
    logic [NUM_VC-1:0] popAccVec;
    logic [NVP-1:0]    fullPad;
    logic [NVP-1:0]    emptyPad;
    logic              pushVcOk;
    logic              popVcOk;
    logic              pushAcc;
    logic              popAcc;
    logic [VCW-1:0]    pushIdx;
    logic [VCW-1:0]    popIdx;
    logic [AW-1:0]     wrAddr;
    logic [AW-1:0]     rdAddr;
    logic [WIDTH-1:0]  mem [ENTRIES];
    logic              overflow_q;
    logic              underflow_q;

    // Padding lets any VC index select a flag; unused VC codes read as full/empty.
    assign fullPad  = NVP'(fullVec) | ~NVP'({NUM_VC{1'b1}});
    assign emptyPad = NVP'(emptyVec) | ~NVP'({NUM_VC{1'b1}});

    assign pushVcOk = (int'(i_push_vc) < NUM_VC);
    assign popVcOk  = (int'(i_pop_vc) < NUM_VC);
    assign pushIdx  = pushVcOk ? i_push_vc : '0;
    assign popIdx   = popVcOk ? i_pop_vc : '0;
    assign pushAcc  = i_push && pushVcOk && !fullPad[i_push_vc];
    assign popAcc   = i_pop && popVcOk && !emptyPad[i_pop_vc];

    assign wrAddr = AW'(int'(pushIdx) * DEPTH + int'(tailArr[pushIdx]));
    assign rdAddr = AW'(int'(popIdx) * DEPTH + int'(headArr[popIdx]));

    for (genvar v = 0; v < NUM_VC; v++) begin : g_queue
        assign pushAccVec[v] = pushAcc && (int'(pushIdx) == v);
        assign popAccVec[v]  = popAcc && (int'(popIdx) == v);

        vc_fifo_qctrl #(
            .DEPTH        (DEPTH),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_qctrl (
            .clk        (clk),
            .rst_n      (rst_n),
            .push_acc_i (pushAccVec[v]),
            .pop_acc_i  (popAccVec[v]),
            .head_o     (headArr[v]),
            .tail_o     (tailArr[v]),
            .count_o    (o_count[v*CW +: CW]),
            .full_o     (fullVec[v]),
            .afull_o    (afullVec[v]),
            .empty_o    (emptyVec[v])
        );
    end

    assign o_full  = fullVec;
    assign o_afull = afullVec;
    assign o_empty = emptyVec;

    // No reset on storage so it maps onto RAM; stale words sit outside head..tail.
    always_ff @(posedge clk) begin
        if (pushAcc) begin
            mem[wrAddr] <= i_wdata;
        end
    end

    if (RLATENCY == 0) begin : g_fwft
        assign o_rvalid = popVcOk && !emptyPad[i_pop_vc];
        assign o_rdata  = o_rvalid ? mem[rdAddr] : '0;
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= popAcc;
                if (popAcc) begin
                    rdata_q <= mem[rdAddr];
                end
            end
        end

        assign o_rvalid = rvalid_q;
        assign o_rdata  = rdata_q;
    end

    // A new error in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_push && !pushAcc) begin
                overflow_q <= 1'b1;
            end else if (i_clr_err) begin
                overflow_q <= 1'b0;
            end
            if (i_pop && !popAcc) begin
                underflow_q <= 1'b1;
            end else if (i_clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench: one FWFT and one registered-read instance share stimulus
// and are compared against per-VC queues modelling the FIFO behaviour.
module tb_vc_fifo;

    localparam int NUM_VC = 2;
    localparam int DEPTH  = 24;
    localparam int WIDTH  = 32;
    localparam int CW     = 5;
    localparam int AFULL  = DEPTH - 2;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              iPush = 1'b0;
    logic [0:0]        iPushVc = '0;
    logic [WIDTH-1:0]  iWdata = '0;
    logic              iPop = 1'b0;
    logic [0:0]        iPopVc = '0;
    logic              iClrErr = 1'b0;

    logic [WIDTH-1:0]     rdata0, rdata1;
    logic                 rvalid0, rvalid1;
    logic [NUM_VC-1:0]    full0, full1, afull0, afull1, empty0, empty1;
    logic [NUM_VC*CW-1:0] count0, count1;
    logic                 ovf0, ovf1, unf0, unf1;

    int checkCount = 0;
    int errorCount = 0;

    logic [WIDTH-1:0] modelQ [NUM_VC][$];
    logic             mOvf = 1'b0;
    logic             mUnf = 1'b0;
    logic             mRvalid1 = 1'b0;
    logic [WIDTH-1:0] mRdata1 = '0;

    typedef struct {
        logic        push;
        logic        pushVc;
        logic [31:0] wdata;
        logic        pop;
        logic        popVc;
        logic        clr;
        int          expCount0;
        int          expCount1;
        logic        expOvf;
        logic        expUnf;
        logic        expRvalid1;
        logic [31:0] expRdata1;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    vc_fifo #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(AFULL), .RLATENCY(0)) dut0 (
        .clk(clk), .rst_n(rstN), .i_push(iPush), .i_push_vc(iPushVc), .i_wdata(iWdata),
        .i_pop(iPop), .i_pop_vc(iPopVc), .o_rdata(rdata0), .o_rvalid(rvalid0),
        .o_full(full0), .o_afull(afull0), .o_empty(empty0), .o_count(count0),
        .o_overflow(ovf0), .o_underflow(unf0), .i_clr_err(iClrErr)
    );

    vc_fifo #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(AFULL), .RLATENCY(1)) dut1 (
        .clk(clk), .rst_n(rstN), .i_push(iPush), .i_push_vc(iPushVc), .i_wdata(iWdata),
        .i_pop(iPop), .i_pop_vc(iPopVc), .o_rdata(rdata1), .o_rvalid(rvalid1),
        .o_full(full1), .o_afull(afull1), .o_empty(empty1), .o_count(count1),
        .o_overflow(ovf1), .o_underflow(unf1), .i_clr_err(iClrErr)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic compareModel();
        for (int v = 0; v < NUM_VC; v++) begin
            int n = modelQ[v].size();
            checkOutput($sformatf("count0[%0d]", v), 64'(count0[v*CW +: CW]), 64'(n));
            checkOutput($sformatf("count1[%0d]", v), 64'(count1[v*CW +: CW]), 64'(n));
            checkOutput($sformatf("full0[%0d]", v), 64'(full0[v]), 64'(n == DEPTH));
            checkOutput($sformatf("full1[%0d]", v), 64'(full1[v]), 64'(n == DEPTH));
            checkOutput($sformatf("afull0[%0d]", v), 64'(afull0[v]), 64'(n >= AFULL));
            checkOutput($sformatf("afull1[%0d]", v), 64'(afull1[v]), 64'(n >= AFULL));
            checkOutput($sformatf("empty0[%0d]", v), 64'(empty0[v]), 64'(n == 0));
            checkOutput($sformatf("empty1[%0d]", v), 64'(empty1[v]), 64'(n == 0));
        end
        checkOutput("overflow0", 64'(ovf0), 64'(mOvf));
        checkOutput("overflow1", 64'(ovf1), 64'(mOvf));
        checkOutput("underflow0", 64'(unf0), 64'(mUnf));
        checkOutput("underflow1", 64'(unf1), 64'(mUnf));
        checkOutput("rvalid1", 64'(rvalid1), 64'(mRvalid1));
        checkOutput("rdata1", 64'(rdata1), 64'(mRdata1));
    endtask

    // One clock cycle: drive at negedge, check the FWFT peek, clock, update model, check.
    task automatic applyStimulus(input logic push, input logic pushVc, input logic [31:0] wdata,
                                 input logic pop, input logic popVc, input logic clr);
        logic             pushOk, popOk, expRv0;
        logic [WIDTH-1:0] expRd0;
        iPush = push; iPushVc = pushVc; iWdata = wdata;
        iPop = pop; iPopVc = popVc; iClrErr = clr;
        #1;
        expRv0 = (modelQ[popVc].size() > 0);
        expRd0 = expRv0 ? modelQ[popVc][0] : '0;
        checkOutput("fwft_rvalid0", 64'(rvalid0), 64'(expRv0));
        checkOutput("fwft_rdata0", 64'(rdata0), 64'(expRd0));
        @(posedge clk);
        pushOk = push && (modelQ[pushVc].size() < DEPTH);
        popOk  = pop && (modelQ[popVc].size() > 0);
        if (popOk) mRdata1 = modelQ[popVc].pop_front();
        mRvalid1 = popOk;
        if (pushOk) modelQ[pushVc].push_back(wdata);
        if (push && !pushOk) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
        if (pop && !popOk) mUnf = 1'b1;
        else if (clr) mUnf = 1'b0;
        @(negedge clk);
        compareModel();
    endtask

    task automatic checkResetState(input string tag);
        for (int v = 0; v < NUM_VC; v++) begin
            checkOutput($sformatf("%s_count[%0d]", tag, v), 64'(count0[v*CW +: CW] | count1[v*CW +: CW]), 64'(0));
        end
        checkOutput({tag, "_empty0"}, 64'(empty0), 64'(2'b11));
        checkOutput({tag, "_empty1"}, 64'(empty1), 64'(2'b11));
        checkOutput({tag, "_full"}, 64'({full0, full1}), 64'(0));
        checkOutput({tag, "_afull"}, 64'({afull0, afull1}), 64'(0));
        checkOutput({tag, "_flags"}, 64'({ovf0, ovf1, unf0, unf1}), 64'(0));
        checkOutput({tag, "_rvalid"}, 64'({rvalid0, rvalid1}), 64'(0));
        checkOutput({tag, "_rdata0"}, 64'(rdata0), 64'(0));
        checkOutput({tag, "_rdata1"}, 64'(rdata1), 64'(0));
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1, 32'h11};
        vecs[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 32'h11};
        vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 32'h11};
        vecs[4] = '{1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0, 32'h11};
        vecs[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1, 32'h33};
        vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 32'h22};
        vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 32'h22};

        repeat (2) @(negedge clk);
        checkResetState("reset");
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pushVc, vecs[i].wdata, vecs[i].pop, vecs[i].popVc, vecs[i].clr);
            checkOutput($sformatf("vec%0d_count0", i), 64'(count0[0 +: CW]), 64'(vecs[i].expCount0));
            checkOutput($sformatf("vec%0d_count1", i), 64'(count1[CW +: CW]), 64'(vecs[i].expCount1));
            checkOutput($sformatf("vec%0d_ovf", i), 64'(ovf1), 64'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0d_unf", i), 64'(unf1), 64'(vecs[i].expUnf));
            checkOutput($sformatf("vec%0d_rvalid1", i), 64'(rvalid1), 64'(vecs[i].expRvalid1));
            checkOutput($sformatf("vec%0d_rdata1", i), 64'(rdata1), 64'(vecs[i].expRdata1));
        end
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] fill VC1");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 1, 32'(i), 0, 0, 0);
            if (i == AFULL - 2) checkOutput("afull_below", 64'(afull0[1]), 64'(0));
            if (i == AFULL - 1) checkOutput("afull_at", 64'(afull1[1]), 64'(1));
        end
        checkOutput("full_vc1", 64'(full0[1]), 64'(1));
        checkOutput("count_vc1_full", 64'(count1[CW +: CW]), 64'(DEPTH));
        checkOutput("vc0_still_empty", 64'(empty0[0]), 64'(1));

        applyStimulus(1, 1, 32'hDEAD, 0, 0, 0);
        checkOutput("ovf_on_full", 64'(ovf0), 64'(1));
        checkOutput("count_after_drop", 64'(count0[CW +: CW]), 64'(DEPTH));
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("ovf_cleared", 64'(ovf0), 64'(0));
        applyStimulus(1, 1, 32'hBEEF, 1, 1, 1);
        checkOutput("ovf_set_beats_clr", 64'(ovf1), 64'(1));
        checkOutput("push_full_with_pop", 64'(count1[CW +: CW]), 64'(DEPTH - 1));
        checkOutput("first_pop_word", 64'(rdata1), 64'(0));
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 0);
            checkOutput("drain_order", 64'(rdata1), 64'(i));
        end
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] pop from empty");
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("unf_on_empty", 64'(unf1), 64'(1));
        checkOutput("rvalid_on_empty", 64'(rvalid1), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] steady push/pop across wrap");
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'(100 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 0, 32'(200 + i), 1, 0, 0);
            checkOutput("wrap_order", 64'(rdata1), (i < 5) ? 64'(100 + i) : 64'(200 + i - 5));
        end
        checkOutput("wrap_count", 64'(count0[0 +: CW]), 64'(5));
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] cross-VC traffic");
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 32'(300 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 32'(400 + i), 1, 1, 0);
            checkOutput("cross_rvalid", 64'(rvalid1), 64'(1));
            checkOutput("cross_rdata", 64'(rdata1), 64'(300 + i));
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rvalid_one_cycle", 64'(rvalid1), 64'(0));
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom,
                          $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 19) == 0);
        end

        $display("[TB] asynchronous reset mid-stream");
        while (modelQ[0].size() > 0) applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        while (modelQ[1].size() < DEPTH) applyStimulus(1, 1, $urandom, 0, 0, 0);
        applyStimulus(1, 1, 32'h1234, 1, 1, 0);
        checkOutput("pre_reset_flags", 64'({ovf0, unf0}), 64'(2'b11));
        iPush = 1'b0; iPop = 1'b0; iPopVc = 1'b1; iClrErr = 1'b0;
        #2 rstN = 1'b0;
        #1 checkResetState("async_reset");
        for (int v = 0; v < NUM_VC; v++) modelQ[v].delete();
        mOvf = 1'b0; mUnf = 1'b0; mRvalid1 = 1'b0; mRdata1 = '0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1, 0, 32'hA5A5A5A5, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("post_reset_word", 64'(rdata1), 64'(32'hA5A5A5A5));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
